// File: rtl/disp_sched_pkg.sv
// rtl/disp_sched_pkg.sv - shared constants and encodings for the display channel scheduler
//
// Purpose: channel count/width and the FSM and mode encodings used by
//          disp_chan_sched and rr_pick8.
// Ports:   none (package).
package disp_sched_pkg;

  localparam int NCH  = 8;
  localparam int CH_W = 3;

  typedef enum logic {
    ST_BASE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_ROTATE = 1'b1
  } mode_e;

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational wrap-around first-set-bit search over 8 channels
//
// Purpose: returns the first set bit of req at or after start, wrapping 7->0.
// Ports:   req   - request/enable vector
//          start - index the search begins at
//          found - any bit of req set
//          idx   - winning index (start when nothing is found)
module rr_pick8
  import disp_sched_pkg::*;
(
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] start,
  output logic            found,
  output logic [CH_W-1:0] idx
);

  // Walk from the farthest offset down to offset 0 so the nearest hit is
  // the last one written and therefore wins.
  always_comb begin
    found = 1'b0;
    idx   = start;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[start + CH_W'(i)]) begin
        found = 1'b1;
        idx   = start + CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/disp_chan_sched.sv
// rtl/disp_chan_sched.sv - channel scheduler for the 8-channel seven-segment display mux
//
// Purpose: chooses the displayed channel from manual switches, a dwell-timed
//          rotation over enabled channels, or an event-driven hold that
//          overrides both.
// Ports:   clk, RSTN   - clock, asynchronous active-low reset
//          mode        - 0 manual, 1 auto-rotate
//          man_sel     - channel shown in manual mode
//          ch_en       - rotation enable mask
//          evt_req     - per-channel event request level (rising edge requests)
//          sel         - registered channel select
//          sel_valid   - low only when rotating with no enabled channel and no hold
//          hold_active - an event channel is being held
//          grant       - one-hot of sel while holding
//          sel_chg     - pulse in the first cycle a new sel value is shown
module disp_chan_sched
  import disp_sched_pkg::*;
#(
  parameter int DWELL_CYC = 50_000_000,
  parameter int HOLD_CYC  = 200_000_000,
  parameter int CNT_W     = 28
) (
  input  logic            clk,
  input  logic            RSTN,
  input  logic            mode,
  input  logic [CH_W-1:0] man_sel,
  input  logic [NCH-1:0]  ch_en,
  input  logic [NCH-1:0]  evt_req,
  output logic [CH_W-1:0] sel,
  output logic            sel_valid,
  output logic            hold_active,
  output logic [NCH-1:0]  grant,
  output logic            sel_chg
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   sel_q, sel_d;
  logic [CH_W-1:0]   rot_sel_q, rot_sel_d;
  logic [CH_W-1:0]   last_gnt_q, last_gnt_d;
  logic [NCH-1:0]    pend_q, pend_d;
  logic [NCH-1:0]    evt_prev_q, evt_prev_d;
  logic              sel_valid_q, sel_valid_d;
  logic              sel_chg_q, sel_chg_d;

  mode_e             mode_i;
  logic [NCH-1:0]    rise;
  logic [NCH-1:0]    pend_set;
  logic [NCH-1:0]    pend_clr;
  logic [CH_W-1:0]   rot_start;
  logic [CH_W-1:0]   arb_start;
  logic              en_found;
  logic [CH_W-1:0]   en_idx;
  logic              pend_found;
  logic [CH_W-1:0]   arb_idx;

  assign mode_i     = mode_e'(mode);
  assign rise       = evt_req & ~evt_prev_q;
  assign rot_start  = sel_q + CH_W'(1);
  assign arb_start  = last_gnt_q + CH_W'(1);
  assign evt_prev_d = evt_req;

  // Next enabled channel after the current one (wraps back to itself when
  // it is the only one enabled, which leaves sel unchanged).
  rr_pick8 u_rot_pick (
    .req   (ch_en),
    .start (rot_start),
    .found (en_found),
    .idx   (en_idx)
  );

  // Round-robin arbitration among pending event requests.
  rr_pick8 u_arb_pick (
    .req   (pend_q),
    .start (arb_start),
    .found (pend_found),
    .idx   (arb_idx)
  );

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= ST_BASE;
      cnt_q       <= '0;
      sel_q       <= '0;
      rot_sel_q   <= '0;
      last_gnt_q  <= CH_W'(NCH - 1);
      pend_q      <= '0;
      evt_prev_q  <= '0;
      sel_valid_q <= 1'b1;
      sel_chg_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      rot_sel_q   <= rot_sel_d;
      last_gnt_q  <= last_gnt_d;
      pend_q      <= pend_d;
      evt_prev_q  <= evt_prev_d;
      sel_valid_q <= sel_valid_d;
      sel_chg_q   <= sel_chg_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    rot_sel_d  = rot_sel_q;
    last_gnt_d = last_gnt_q;
    pend_set   = rise;
    pend_clr   = '0;

    case (state_q)
      ST_BASE: begin
        if (pend_found) begin
          // Pending events pre-empt both manual selection and the dwell.
          state_d            = ST_HOLD;
          sel_d              = arb_idx;
          last_gnt_d         = arb_idx;
          pend_clr[arb_idx]  = 1'b1;
          cnt_d              = '0;
          rot_sel_d          = sel_q;
        end else if (mode_i == MODE_MANUAL) begin
          sel_d = man_sel;
          cnt_d = '0;
        end else if (!en_found) begin
          cnt_d = '0;
        end else if (!ch_en[sel_q] || cnt_q == DWELL_LAST) begin
          // A disabled current channel is left immediately.
          sel_d = en_idx;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_HOLD: begin
        // An edge on the held channel retriggers rather than queues.
        pend_set[sel_q] = 1'b0;
        if (rise[sel_q]) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          if (pend_found) begin
            sel_d             = arb_idx;
            last_gnt_d        = arb_idx;
            pend_clr[arb_idx] = 1'b1;
          end else begin
            state_d = ST_BASE;
            sel_d   = (mode_i == MODE_ROTATE) ? rot_sel_q : man_sel;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_BASE;
      end
    endcase

    // Set after clear so a new edge on the just-granted channel survives.
    pend_d      = (pend_q & ~pend_clr) | pend_set;
    sel_valid_d = (state_d == ST_HOLD) || !(mode_i == MODE_ROTATE && !en_found);
    sel_chg_d   = (sel_d != sel_q);
  end

  always_comb begin
    hold_active = (state_q == ST_HOLD);
    grant       = '0;
    if (state_q == ST_HOLD) begin
      grant[sel_q] = 1'b1;
    end
  end

  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
  assign sel_chg   = sel_chg_q;

endmodule

// File: tb/tb_disp_chan_sched.sv
// tb/tb_disp_chan_sched.sv - directed self-checking bench for disp_chan_sched
module tb_disp_chan_sched;

  localparam int DWELL = 4;
  localparam int HOLD  = 6;

  logic       clk;
  logic       RSTN;
  logic       mode;
  logic [2:0] man_sel;
  logic [7:0] ch_en;
  logic [7:0] evt_req;
  logic [2:0] sel;
  logic       sel_valid;
  logic       hold_active;
  logic [7:0] grant;
  logic       sel_chg;

  int n_vec  = 0;
  int n_miss = 0;
  bit started = 1'b0;
  bit saw2;

  disp_chan_sched #(
    .DWELL_CYC (DWELL),
    .HOLD_CYC  (HOLD),
    .CNT_W     (28)
  ) dut (
    .clk         (clk),
    .RSTN        (RSTN),
    .mode        (mode),
    .man_sel     (man_sel),
    .ch_en       (ch_en),
    .evt_req     (evt_req),
    .sel         (sel),
    .sel_valid   (sel_valid),
    .hold_active (hold_active),
    .grant       (grant),
    .sel_chg     (sel_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int       m_sel, m_rot, m_last, m_hold_left, m_dwell_left;
  bit       m_hold, m_valid, m_chg;
  bit [7:0] m_pend, m_prev;

  function automatic int next_from(input bit [7:0] mask, input int from);
    for (int k = 0; k < 8; k++) begin
      if (mask[(from + k) % 8]) return (from + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_sel = 0; m_rot = 0; m_last = 7;
    m_hold = 0; m_valid = 1; m_chg = 0;
    m_pend = '0; m_prev = '0;
    m_hold_left = HOLD; m_dwell_left = DWELL;
  endtask

  task automatic model_step();
    bit [7:0] rise;
    int nsel;
    int w;
    rise   = evt_req & ~m_prev;
    m_prev = evt_req;
    nsel   = m_sel;
    w      = next_from(m_pend, (m_last + 1) % 8);
    if (m_hold) begin
      if (rise[m_sel]) begin
        rise[m_sel] = 1'b0;
        m_hold_left = HOLD;
      end else if (m_hold_left == 1) begin
        if (w >= 0) begin
          nsel = w; m_last = w; m_pend[w] = 1'b0; m_hold_left = HOLD;
        end else begin
          m_hold = 0;
          m_dwell_left = DWELL;
          nsel = mode ? m_rot : int'(man_sel);
        end
      end else begin
        m_hold_left--;
      end
    end else if (w >= 0) begin
      m_hold = 1; m_rot = m_sel;
      nsel = w; m_last = w; m_pend[w] = 1'b0; m_hold_left = HOLD;
    end else if (!mode) begin
      nsel = man_sel; m_dwell_left = DWELL;
    end else if (ch_en == 8'h00) begin
      m_dwell_left = DWELL;
    end else if (!ch_en[m_sel] || m_dwell_left == 1) begin
      nsel = next_from(ch_en, (m_sel + 1) % 8);
      m_dwell_left = DWELL;
    end else begin
      m_dwell_left--;
    end
    m_pend  = m_pend | rise;
    m_valid = m_hold || !(mode && ch_en == 8'h00);
    m_chg   = (nsel != m_sel);
    m_sel   = nsel;
  endtask

  always @(posedge clk or negedge RSTN) begin
    if (!RSTN) model_reset();
    else       model_step();
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_sel",         32'(sel),         32'(m_sel));
      chk("m_sel_valid",   32'(sel_valid),   32'(m_valid));
      chk("m_hold_active", 32'(hold_active), 32'(m_hold));
      chk("m_grant",       32'(grant),       m_hold ? (32'd1 << m_sel) : 32'd0);
      chk("m_sel_chg",     32'(sel_chg),     32'(m_chg));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    RSTN = 1'b0; mode = 1'b0; man_sel = 3'd5; ch_en = 8'h00; evt_req = 8'h00;
    @(posedge clk);
    started = 1'b1;
    step(); step();
    chk("rst_sel", 32'(sel), 0);
    chk("rst_valid", 32'(sel_valid), 1);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_chg", 32'(sel_chg), 0);
    RSTN = 1'b1;
    step(); chk("man_sel5", 32'(sel), 5); chk("man_chg", 32'(sel_chg), 1);
    step(); chk("man_chg_off", 32'(sel_chg), 0);
    man_sel = 3'd2;
    step(); chk("man_sel2", 32'(sel), 2);

    // rotation 2 -> 5 -> 7 -> 2
    mode = 1'b1; ch_en = 8'b1010_0100;
    step(); step(); step(); chk("rot_2", 32'(sel), 2);
    step(); chk("rot_5", 32'(sel), 5);
    repeat (4) step(); chk("rot_7", 32'(sel), 7);
    repeat (4) step(); chk("rot_wrap2", 32'(sel), 2);
    repeat (4) step(); chk("rot_5b", 32'(sel), 5);
    ch_en = 8'b1000_0100;
    step(); chk("skip_dis", 32'(sel), 7); chk("skip_chg", 32'(sel_chg), 1);

    // no enabled channel, then event on channel 3
    ch_en = 8'h00;
    step(); chk("en0_valid", 32'(sel_valid), 0);
    repeat (3) step(); chk("en0_frozen", 32'(sel), 7);
    evt_req = 8'h08; step(); evt_req = 8'h00; step();
    chk("ev3_sel", 32'(sel), 3);
    chk("ev3_hold", 32'(hold_active), 1);
    chk("ev3_grant", 32'(grant), 32'h08);
    chk("ev3_valid", 32'(sel_valid), 1);
    repeat (5) step(); chk("ev3_still", 32'(grant), 32'h08);
    step();
    chk("ev3_end", 32'(hold_active), 0);
    chk("ev3_back_valid", 32'(sel_valid), 0);
    chk("ev3_back_sel", 32'(sel), 7);

    // reset to last_gnt=7, then simultaneous requests on 1 and 6
    RSTN = 1'b0; step(); RSTN = 1'b1; ch_en = 8'b1010_0100;
    step(); chk("rst2_adv", 32'(sel), 2);
    evt_req = 8'h42; step(); evt_req = 8'h00; step();
    chk("rr_first", 32'(grant), 32'h02);
    repeat (5) step(); chk("rr_first_hold", 32'(sel), 1);
    step(); chk("rr_second", 32'(grant), 32'h40); chk("rr_second_act", 32'(hold_active), 1);
    repeat (5) step(); chk("rr_second_hold", 32'(sel), 6);
    step(); chk("rr_resume", 32'(sel), 2); chk("rr_resume_hold", 32'(hold_active), 0);
    repeat (4) step(); chk("rr_resume_dwell", 32'(sel), 5);

    // retrigger of a held channel
    evt_req = 8'h10; step(); evt_req = 8'h00; step();
    chk("rt_sel", 32'(sel), 4);
    repeat (3) step();
    evt_req = 8'h10; step(); evt_req = 8'h00;
    repeat (5) step(); chk("rt_ext", 32'(grant), 32'h10);
    step(); chk("rt_exit", 32'(hold_active), 0); chk("rt_exit_sel", 32'(sel), 5);
    repeat (2) step(); chk("rt_no_regrant", 32'(hold_active), 0);

    // reset in the middle of a hold with channel 2 pending
    evt_req = 8'h08; step(); evt_req = 8'h00; step();
    chk("rh_sel", 32'(sel), 3);
    evt_req = 8'h04; step();
    RSTN = 1'b0; #1;
    chk("rh_rst_sel", 32'(sel), 0);
    chk("rh_rst_hold", 32'(hold_active), 0);
    chk("rh_rst_grant", 32'(grant), 0);
    chk("rh_rst_valid", 32'(sel_valid), 1);
    chk("rh_rst_chg", 32'(sel_chg), 0);
    evt_req = 8'h00;
    step(); step(); RSTN = 1'b1;
    saw2 = 1'b0;
    repeat (20) begin
      step();
      if (grant[2]) saw2 = 1'b1;
    end
    chk("rh_no_ch2", 32'(saw2), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
